// File: rtl/cpu_pkg.sv
// Shared constants for the 5-stage RISC-V core: special instruction
// encodings, fetch-stage run-control state codes and the PC step.
package cpu_pkg;

  // End-of-program marker recognised by the fetch stage
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  // Fetch run-control states
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;

  // Sequential fetch advances one 32-bit word
  localparam int PC_INC = 4;

endpackage : cpu_pkg

// File: rtl/if_stage_instr_mem.sv
// Instruction memory: one synchronous write port used by the debug unit
// to load a program, one asynchronous read port used by fetch. There is
// no reset, so a loaded program survives a core reset. A read of the
// address being written returns the old word until the next cycle.
module instr_mem #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [0:DEPTH-1];

  // Program-load write, accepted in any run state
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Zero-latency read; IF/ID is the register that captures it
  assign o_rd_data = mem[i_rd_addr];

endmodule : instr_mem

// File: rtl/if_stage.sv
// Instruction-fetch stage. Holds the PC, reads instruction memory and
// presents instr / pc / pc+4 to the IF/ID register. Applies ID-stage
// redirects and hazard stalls, and tracks IDLE/RUN/HALT run control for
// the debug unit.
//
// IF/ID interface: o_fetch_en is the valid for the IF/ID register; when
// it is high, IF/ID captures o_instr, o_pc and o_pc_next on that rising
// edge. There is no ready: the hazard unit's i_stall is the backpressure
// and, in the same cycle, drops o_fetch_en and holds the PC.
module if_stage
  import cpu_pkg::*;
#(
  parameter int                  NB_INSTR   = 32,
  parameter int                  NB_PC      = 32,
  parameter int                  IMEM_AW    = 10,
  parameter logic [NB_INSTR-1:0] HALT_INSTR = cpu_pkg::HALT_INSTR
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_en,
  input  logic                i_stall,
  input  logic                i_pc_src,
  input  logic [NB_PC-1:0]    i_pc_target,
  input  logic                i_imem_wr_en,
  input  logic [IMEM_AW-1:0]  i_imem_wr_addr,
  input  logic [NB_INSTR-1:0] i_imem_wr_data,
  output logic [NB_INSTR-1:0] o_instr,
  output logic [NB_PC-1:0]    o_pc,
  output logic [NB_PC-1:0]    o_pc_next,
  output logic                o_fetch_en,
  output logic                o_halt,
  output logic [1:0]          o_state
);

  logic [NB_PC-1:0]   pc_q;
  logic [NB_PC-1:0]   pc_d;
  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [NB_PC-1:0]   pc_inc;
  logic [NB_PC-1:0]   pc_redirect;
  logic [IMEM_AW-1:0] rd_word_addr;
  logic               is_halt_word;

  // Word index into imem; higher PC bits are dropped, so large
  // addresses alias onto the memory
  assign rd_word_addr = pc_q[IMEM_AW+1:2];

  instr_mem #(
    .AW (IMEM_AW),
    .DW (NB_INSTR)
  ) u_imem (
    .clk       (clk),
    .i_wr_en   (i_imem_wr_en),
    .i_wr_addr (i_imem_wr_addr),
    .i_wr_data (i_imem_wr_data),
    .i_rd_addr (rd_word_addr),
    .o_rd_data (o_instr)
  );

  // Sequential successor wraps modulo 2**NB_PC
  assign pc_inc       = pc_q + NB_PC'(PC_INC);
  // Redirect targets are forced word-aligned; no misalignment trap
  assign pc_redirect  = {i_pc_target[NB_PC-1:2], 2'b00};
  assign is_halt_word = (o_instr == HALT_INSTR);

  // Next PC and run state; i_en low freezes everything
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_en && i_start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_en) begin
          if (i_pc_src) begin
            // Redirect wins over stall and cancels a wrong-path halt
            pc_d = pc_redirect;
          end else if (i_stall) begin
            // Hold; a halt word under stall is re-evaluated next cycle
            pc_d = pc_q;
          end else if (is_halt_word) begin
            // Halt word itself goes to IF/ID this cycle; PC stays on it
            state_d = ST_HALT;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      ST_HALT: begin
        // Only reset leaves HALT
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  // PC and state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (i_rst) begin
      pc_q    <= '0;
      state_q <= ST_IDLE;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign o_pc       = pc_q;
  assign o_pc_next  = pc_inc;
  assign o_fetch_en = (state_q == ST_RUN) && i_en && !i_stall;
  assign o_halt     = (state_q == ST_HALT);
  assign o_state    = state_q;

endmodule : if_stage

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed program-load / run / redirect / stall /
// halt / reset sequences, a behavioural reference model of the fetch
// stage checked every cycle, and hand-computed literal checkpoints.
module tb_if_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk;
  logic        i_rst;
  logic        i_start;
  logic        i_en;
  logic        i_stall;
  logic        i_pc_src;
  logic [31:0] i_pc_target;
  logic        i_imem_wr_en;
  logic [9:0]  i_imem_wr_addr;
  logic [31:0] i_imem_wr_data;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [31:0] o_pc_next;
  logic        o_fetch_en;
  logic        o_halt;
  logic [1:0]  o_state;

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  if_stage dut (
    .clk            (clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_en           (i_en),
    .i_stall        (i_stall),
    .i_pc_src       (i_pc_src),
    .i_pc_target    (i_pc_target),
    .i_imem_wr_en   (i_imem_wr_en),
    .i_imem_wr_addr (i_imem_wr_addr),
    .i_imem_wr_data (i_imem_wr_data),
    .o_instr        (o_instr),
    .o_pc           (o_pc),
    .o_pc_next      (o_pc_next),
    .o_fetch_en     (o_fetch_en),
    .o_halt         (o_halt),
    .o_state        (o_state)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_mem [0:1023];
  logic [31:0] m_pc      = 32'd0;
  bit          m_running = 0;
  bit          m_halted  = 0;

  always @(posedge clk) begin
    logic [31:0] cur;
    cur = m_mem[m_pc[11:2]];
    if (i_rst) begin
      m_pc = 32'd0;
      m_running = 0;
      m_halted = 0;
    end else if (i_en && !m_halted) begin
      if (!m_running) begin
        if (i_start) m_running = 1;
      end else if (i_pc_src) begin
        m_pc = i_pc_target & 32'hFFFF_FFFC;
      end else if (!i_stall) begin
        if (cur == HALT) begin
          m_halted = 1;
          m_running = 0;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
    if (i_imem_wr_en) m_mem[i_imem_wr_addr] = i_imem_wr_data;
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_instr",   o_instr,           m_mem[m_pc[11:2]]);
      chk("m_pc",      o_pc,              m_pc);
      chk("m_pc_next", o_pc_next,         m_pc + 32'd4);
      chk("m_fetch",   32'(o_fetch_en),   32'(m_running && i_en && !i_stall));
      chk("m_halt",    32'(o_halt),       32'(m_halted));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    i_imem_wr_en   = 1'b1;
    i_imem_wr_addr = a;
    i_imem_wr_data = d;
    tick();
    i_imem_wr_en   = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] t);
    i_pc_src    = 1'b1;
    i_pc_target = t;
    tick();
    i_pc_src    = 1'b0;
  endtask

  task automatic do_reset_start();
    i_rst = 1'b1;
    tick();
    i_rst   = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // ---------------- directed sequences ----------------
  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_en = 1'b1; i_stall = 1'b0;
    i_pc_src = 1'b0; i_pc_target = '0;
    i_imem_wr_en = 1'b0; i_imem_wr_addr = '0; i_imem_wr_data = '0;

    // Fill the whole memory with NOPs under reset so every read is known
    for (int i = 0; i < 1024; i++) load(10'(i), NOP);
    chk_on = 1;

    // Reset state
    tick();
    chk("rst_pc",      o_pc,              32'h0);
    chk("rst_pc_next", o_pc_next,         32'h4);
    chk("rst_halt",    32'(o_halt),       32'h0);
    chk("rst_fetch",   32'(o_fetch_en),   32'h0);
    chk("rst_instr",   o_instr,           NOP);

    // 1: program load, run to halt
    load(10'd0, NOP);
    load(10'd1, 32'h0010_0093);
    load(10'd2, 32'h0020_0113);
    load(10'd3, HALT);
    i_rst = 1'b0; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("t1_pc0",   o_pc, 32'h0);
    chk("t1_fe0",   32'(o_fetch_en), 32'h1);
    tick(); chk("t1_pc4",  o_pc, 32'h4);
    chk("t1_ins4", o_instr, 32'h0010_0093);
    tick(); chk("t1_pc8",  o_pc, 32'h8);
    tick(); chk("t1_pc12", o_pc, 32'hC);
    chk("t1_ins12", o_instr, HALT);
    tick();
    chk("t1_halt",  32'(o_halt), 32'h1);
    chk("t1_pch",   o_pc, 32'hC);
    chk("t1_feh",   32'(o_fetch_en), 32'h0);
    i_start = 1'b1;
    tick(); tick();
    i_start = 1'b0;
    chk("t1_stay",  o_pc, 32'hC);
    chk("t1_stayh", 32'(o_halt), 32'h1);

    // 6: reset out of HALT keeps memory
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("t6_pc",    o_pc, 32'h0);
    chk("t6_halt",  32'(o_halt), 32'h0);
    chk("t6_instr", o_instr, NOP);

    // 2: redirect, and redirect beating stall
    i_start = 1'b1; tick(); i_start = 1'b0;
    tick(); tick();
    chk("t2_pc8", o_pc, 32'h8);
    redirect(32'h0000_0023);
    chk("t2_redir", o_pc, 32'h20);
    redirect(32'h0000_000B);
    chk("t2_back", o_pc, 32'h8);
    i_stall = 1'b1;
    redirect(32'h0000_0023);
    i_stall = 1'b0;
    chk("t2_rstall", o_pc, 32'h20);

    // 3: stall holds PC for three cycles
    redirect(32'h4);
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold", o_pc, 32'h4);
      chk("t3_fe",   32'(o_fetch_en), 32'h0);
    end
    i_stall = 1'b0;
    #1 chk("t3_fe_rel", 32'(o_fetch_en), 32'h1);
    tick();
    chk("t3_adv", o_pc, 32'h8);

    // 4: wrong-path halt cancelled by a same-cycle redirect
    i_en = 1'b0;
    load(10'd5, HALT);
    i_en = 1'b1;
    redirect(32'h14);
    chk("t4_athalt", o_instr, HALT);
    redirect(32'h40);
    chk("t4_pc",   o_pc, 32'h40);
    chk("t4_halt", 32'(o_halt), 32'h0);
    // Halt under stall waits for the stall to clear
    redirect(32'h14);
    i_stall = 1'b1;
    tick();
    chk("t4_st_pc",   o_pc, 32'h14);
    chk("t4_st_halt", 32'(o_halt), 32'h0);
    i_stall = 1'b0;
    tick();
    chk("t4_halted", 32'(o_halt), 32'h1);
    chk("t4_hpc",    o_pc, 32'h14);

    // 5: enable low freezes; write-then-read ordering
    do_reset_start();
    tick(); tick();
    chk("t5_pc8", o_pc, 32'h8);
    i_en = 1'b0;
    tick(); tick();
    chk("t5_frz", o_pc, 32'h8);
    i_imem_wr_en = 1'b1; i_imem_wr_addr = 10'd2; i_imem_wr_data = 32'hDEAD_BEEF;
    #1 chk("t5_old", o_instr, 32'h0020_0113);
    tick();
    i_imem_wr_en = 1'b0;
    chk("t5_new", o_instr, 32'hDEAD_BEEF);
    i_en = 1'b1;
    tick();
    chk("t5_pc12", o_pc, 32'hC);
    tick();
    chk("t5_halt", 32'(o_halt), 32'h1);

    // PC wrap and address aliasing
    do_reset_start();
    redirect(32'hFFFF_FFFF);
    chk("w_pc",    o_pc, 32'hFFFF_FFFC);
    chk("w_next",  o_pc_next, 32'h0);
    chk("w_instr", o_instr, NOP);
    tick();
    chk("w_wrap",  o_pc, 32'h0);
    redirect(32'h0000_1014);
    chk("a_instr", o_instr, HALT);
    tick();
    chk("a_halt",  32'(o_halt), 32'h1);
    chk("a_pc",    o_pc, 32'h1014);

    tick(); tick();
    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_if_stage
